// File: rtl/jtcps1_pal_dma.sv
// CPS1 palette RAM with a VB-synchronised VRAM-to-palette page copier.
// Optional double buffering of the palette RAM: define JTCPS1_PAL_DBUF_EN.
module jtcps1_pal_dma #(
    parameter int PAGES = 6,
    parameter int AW    = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          VB,
    input  logic          pal_copy,
    input  logic [15:0]   pal_base,
    input  logic [5:0]    pal_page_en,
    output logic [AW-1:0] vram_addr,
    output logic          vram_cs,
    input  logic          vram_ok,
    input  logic [15:0]   vram_data,
    input  logic [11:0]   pal_addr,
    output logic [15:0]   pal_raw,
    output logic          busy
);

    localparam int PW = $clog2(PAGES + 1);

    typedef enum logic [2:0] {IDLE, WAIT_VB, PAGE, REQ, DONE} state_t;

    state_t          state;
    logic            vb_l;
    logic            pending;
    logic [15:0]     base_r;
    logic [5:0]      en_r;
    logic [PW-1:0]   page;
    logic [12:0]     offset;
    logic            vb_rise;
    logic            word_ok;
    logic [AW-1:0]   req_addr;

    assign vb_rise  = VB & ~vb_l;
    assign word_ok  = (state == REQ) & vram_cs & vram_ok;
    assign req_addr = AW'({base_r, 7'd0}) + AW'(offset);
    assign busy     = (state != IDLE) | pending;

`ifdef JTCPS1_PAL_DBUF_EN
    logic [15:0] ram [0:8191];
    logic        front;
    logic        swap_pend;
    logic [12:0] wr_addr;
    logic [12:0] rd_addr;

    assign wr_addr = {~front, offset[11:0]};
    assign rd_addr = {front, pal_addr};

    // Completed back bank becomes visible only at the next frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front     <= 1'b0;
            swap_pend <= 1'b0;
        end else if (state == DONE) begin
            swap_pend <= 1'b1;
        end else if (swap_pend && vb_rise) begin
            front     <= ~front;
            swap_pend <= 1'b0;
        end
    end
`else
    logic [15:0] ram [0:4095];
    logic [11:0] wr_addr;
    logic [11:0] rd_addr;

    assign wr_addr = offset[11:0];
    assign rd_addr = pal_addr;
`endif

    always_ff @(posedge clk) begin
        if (word_ok) ram[wr_addr] <= vram_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pal_raw <= '0;
        else        pal_raw <= ram[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vb_l      <= 1'b1;
            pending   <= 1'b0;
            base_r    <= '0;
            en_r      <= '0;
            page      <= '0;
            offset    <= '0;
            vram_cs   <= 1'b0;
            vram_addr <= '0;
        end else begin
            vb_l <= VB;
            if (pal_copy && state != IDLE) pending <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (pal_copy) state <= WAIT_VB;
                end
                WAIT_VB: begin
                    if (vb_rise) begin
                        state  <= PAGE;
                        base_r <= pal_base;
                        en_r   <= pal_page_en;
                        page   <= '0;
                        offset <= '0;
                    end
                end
                PAGE: begin
                    if (page == PW'(PAGES)) begin
                        state <= DONE;
                    end else if (en_r[page]) begin
                        state <= REQ;
                    end else begin
                        offset <= offset + 13'd512;
                        page   <= page + 1'b1;
                    end
                end
                REQ: begin
                    // Request is issued one clk after entry/acceptance so the address is registered
                    if (!vram_cs) begin
                        vram_cs   <= 1'b1;
                        vram_addr <= req_addr;
                    end else if (vram_ok) begin
                        vram_cs <= 1'b0;
                        offset  <= offset + 13'd1;
                        if (offset[8:0] == 9'h1FF) begin
                            page  <= page + 1'b1;
                            state <= PAGE;
                        end
                    end
                end
                DONE: begin
                    state   <= (pending || pal_copy) ? WAIT_VB : IDLE;
                    pending <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
